imm_pack: RTL and testbench

- Streaming immediate encoder; the inverse of the decode-side sign extender.
- Takes an 18-bit signed immediate plus a 34-bit instruction template.
- Picks the narrowest ImmSrc format that sign-extends back to the exact value, then packs the field into the instruction word.
- Sits in the instruction-generation / program-loader path ahead of instruction memory.
- Elastic 2-stage valid/ready pipeline.

---
 rtl/imm_pkg.sv | 38 +++
 rtl/imm_classify.sv | 29 ++
 rtl/imm_pack.sv | 107 ++++++++++
 tb/tb_imm_pack.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types, widths, range limits and packing helper for imm_pack
package imm_pkg;

  localparam int INSTR_W = 34;
  localparam int DATA_W  = 18;
  localparam int FIELD_W = 16;

  typedef enum logic [1:0] {
    IMM_10   = 2'b00,
    IMM_16   = 2'b01,
    IMM_2    = 2'b10,
    IMM_NONE = 2'b11
  } imm_src_t;

  localparam int IMM2_MIN  = -2;
  localparam int IMM2_MAX  = 1;
  localparam int IMM10_MIN = -512;
  localparam int IMM10_MAX = 511;
  localparam int IMM16_MIN = -32768;
  localparam int IMM16_MAX = 32767;

  // Replace the low bits of the template with the field; unencodable clears [15:0].
  function automatic logic [INSTR_W-1:0] pack_field(
    input logic [INSTR_W-1:0] tmpl,
    input imm_src_t           src,
    input logic [FIELD_W-1:0] field
  );
    logic [INSTR_W-1:0] r;
    case (src)
      IMM_2:   r = {tmpl[INSTR_W-1:2], field[1:0]};
      IMM_10:  r = {tmpl[INSTR_W-1:10], field[9:0]};
      IMM_16:  r = {tmpl[INSTR_W-1:16], field};
      default: r = {tmpl[INSTR_W-1:16], 16'h0000};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_classify.sv
// rtl/imm_classify.sv - picks the narrowest format that sign-extends back to the immediate
module imm_classify
  import imm_pkg::*;
(
  input  logic [DATA_W-1:0]  imm,
  output imm_src_t           src,
  output logic [FIELD_W-1:0] field
);

  logic signed [31:0] v;

  // Narrowest-first range test; field carries only the bits the chosen format keeps.
  always_comb begin
    v     = 32'(signed'(imm));
    src   = IMM_NONE;
    field = '0;
    if (v >= IMM2_MIN && v <= IMM2_MAX) begin
      src   = IMM_2;
      field = {14'h0, imm[1:0]};
    end else if (v >= IMM10_MIN && v <= IMM10_MAX) begin
      src   = IMM_10;
      field = {6'h0, imm[9:0]};
    end else if (v >= IMM16_MIN && v <= IMM16_MAX) begin
      src   = IMM_16;
      field = imm[15:0];
    end
  end

endmodule

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - 2-stage elastic immediate encoder; IMM_PACK_STATS_EN adds per-format counters
module imm_pack
  import imm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic [INSTR_W-1:0] in_tmpl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         out_imm_src,
  output logic               out_err,
  output logic [CNT_W-1:0]   err_cnt
`ifdef IMM_PACK_STATS_EN
  ,
  output logic [CNT_W-1:0]   cnt_short,
  output logic [CNT_W-1:0]   cnt_mid,
  output logic [CNT_W-1:0]   cnt_wide
`endif
);

  imm_src_t           cls_src;
  logic [FIELD_W-1:0] cls_field;

  logic               s1_valid;
  imm_src_t           s1_src;
  logic [FIELD_W-1:0] s1_field;
  logic [INSTR_W-1:0] s1_tmpl;

  logic s2_load;
  logic accept;

  imm_classify u_classify (
    .imm   (in_imm),
    .src   (cls_src),
    .field (cls_field)
  );

  // in_ready depends only on registered state and out_ready, never on in_valid.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  // Stage 1: capture classification, field and template of the accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_src   <= IMM_NONE;
      s1_field <= '0;
      s1_tmpl  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_src   <= cls_src;
        s1_field <= cls_field;
        s1_tmpl  <= in_tmpl;
      end
    end
  end

  // Stage 2: output register; holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_imm_src <= IMM_NONE;
      out_err     <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr   <= pack_field(s1_tmpl, s1_src, s1_field);
        out_imm_src <= s1_src;
        out_err     <= (s1_src == IMM_NONE);
      end
    end
  end

  // Error counter counts unencodable beats at acceptance and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (accept && cls_src == IMM_NONE && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

`ifdef IMM_PACK_STATS_EN
  // Per-format statistics, saturating, counted at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_short <= '0;
      cnt_mid   <= '0;
      cnt_wide  <= '0;
    end else if (accept) begin
      if (cls_src == IMM_2 && cnt_short != '1) cnt_short <= cnt_short + 1'b1;
      if (cls_src == IMM_10 && cnt_mid != '1) cnt_mid <= cnt_mid + 1'b1;
      if (cls_src == IMM_16 && cnt_wide != '1) cnt_wide <= cnt_wide + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_pack.sv
// tb/tb_imm_pack.sv - scoreboard bench for imm_pack with an arithmetic reference model
`timescale 1ns/1ps
module tb_imm_pack;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] in_imm = '0;
  logic [33:0] in_tmpl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [33:0] out_instr;
  logic [1:0]  out_imm_src;
  logic        out_err;
  logic [CNT_W-1:0] err_cnt;
`ifdef IMM_PACK_STATS_EN
  logic [CNT_W-1:0] cnt_short, cnt_mid, cnt_wide;
`endif

  imm_pack #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_imm      (in_imm),
    .in_tmpl     (in_tmpl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_imm_src (out_imm_src),
    .out_err     (out_err),
    .err_cnt     (err_cnt)
`ifdef IMM_PACK_STATS_EN
    ,
    .cnt_short   (cnt_short),
    .cnt_mid     (cnt_mid),
    .cnt_wide    (cnt_wide)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] instr;
    logic [1:0]  src;
    logic        err;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int exp_err = 0;
  int exp_short = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  bit rnd_ready = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: narrowest signed range wins; field is v masked to the format width.
  function automatic exp_t model(input logic [17:0] imm, input logic [33:0] tmpl);
    exp_t   e;
    int     v;
    int     w;
    longint mask;
    longint f;
    v = int'($signed(imm));
    e.err = 1'b0;
    if (v >= -2 && v <= 1) begin
      w = 2;  e.src = 2'b10;
    end else if (v >= -512 && v <= 511) begin
      w = 10; e.src = 2'b00;
    end else if (v >= -32768 && v <= 32767) begin
      w = 16; e.src = 2'b01;
    end else begin
      w = 16; e.src = 2'b11; e.err = 1'b1;
    end
    mask = (longint'(1) << w) - 1;
    f = e.err ? 64'd0 : (longint'(v) & mask);
    e.instr = 34'((longint'(tmpl) & ~mask) | f);
    return e;
  endfunction

  // Drive one beat and hold it until accepted; the expected result is queued at acceptance.
  task automatic send(input logic [17:0] imm, input logic [33:0] tmpl);
    exp_t e;
    bit   acc;
    int   n;
    n = 0;
    e = model(imm, tmpl);
    in_valid = 1'b1;
    in_imm   = imm;
    in_tmpl  = tmpl;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end while (!acc && n < 200);
    if (acc) begin
      q.push_back(e);
      acc_cnt++;
      if (e.err && exp_err < CNT_MAX) exp_err++;
      if (e.src == 2'b10 && exp_short < CNT_MAX) exp_short++;
    end else begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", n);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    exp_err = 0;
    exp_short = 0;
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", q.size());
    end
    #1;
  endtask

  // Monitor: compare the presented beat to the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("err_cnt", err_cnt, exp_err);
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got instr 0x%0h, expected no beat", out_instr);
        end else begin
          check("out_instr", out_instr, q[0].instr);
          check("out_imm_src", out_imm_src, q[0].src);
          check("out_err", out_err, q[0].err);
          if (out_ready) begin
            void'(q.pop_front());
            pop_cnt++;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  logic [17:0] bnd_imm [10] = '{18'h3FFFE, 18'h00001, 18'h00002, 18'h001FF, 18'h00200,
                                18'h3FE00, 18'h08000, 18'h37FFF, 18'h38000, 18'h3FFFF};

  initial begin
    int v;
    int a0;
    int p0;
    logic [17:0] imm;
    logic [33:0] tmpl;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_instr", out_instr, 0);
    check("reset_out_imm_src", out_imm_src, 2'b11);
    check("reset_out_err", out_err, 0);
    check("reset_err_cnt", err_cnt, 0);
    check("reset_in_ready", in_ready, 1);

    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(bnd_imm[i], 34'h0);
    send(18'h00005, 34'h3FFFFFFFF);
    drain();
    check("err_cnt_after_boundaries", err_cnt, 2);
    check("passthrough_model", model(18'h00005, 34'h3FFFFFFFF).instr, 34'h3FFFFFC05);

    rnd_ready = 1;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 7)) - 4;
        1:       v = int'($urandom_range(0, 1200)) - 600;
        2:       v = int'($urandom_range(0, 70000)) - 35000;
        default: v = int'($urandom_range(0, 262143)) - 131072;
      endcase
      imm  = 18'(v);
      tmpl = {2'($urandom), $urandom};
      send(imm, tmpl);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    rnd_ready = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    a0 = acc_cnt;
    fork
      for (int i = 0; i < 5; i++) send(18'(i * 300 + 1), {2'($urandom), $urandom});
    join_none
    repeat (6) @(posedge clk);
    #1;
    check("bp_accepts_while_stalled", acc_cnt - a0, 2);
    check("bp_in_ready_low", in_ready, 0);
    p0 = pop_cnt;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("bp_release_throughput", pop_cnt - p0, 5);
    wait fork;
    drain();
    check("bp_accepts_total", acc_cnt - a0, 5);

    out_ready = 1'b0;
    send(18'h08000, 34'h1);
    send(18'h00003, 34'h2);
    check("midrst_in_ready_full", in_ready, 0);
    do_reset();
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++) begin
      v = 32768 + int'($urandom_range(0, 98000));
      if ($urandom_range(0, 1) == 1) v = -v - 1;
      send(18'(v), {2'($urandom), $urandom});
    end
    drain();
    check("err_cnt_saturated", err_cnt, CNT_MAX);
    send(18'h20000, 34'h0);
    drain();
    check("err_cnt_stays_saturated", err_cnt, CNT_MAX);

`ifdef IMM_PACK_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) send(18'h3FFFF, 34'h0);
    drain();
    check("cnt_short", cnt_short, exp_short);
    check("cnt_mid", cnt_mid, 0);
    check("cnt_wide", cnt_wide, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
